// File: rtl/cmp_minmax_seq.sv
// Sequencer that time-shares one 4-bit comparator to find the max/min of a
// run of COUNT unsigned samples, plus the first index of each.

module cmp (
  input  logic [3:0] num1_i,
  input  logic [3:0] num2_i,
  output logic       gt_o,
  output logic       lt_o
);
  assign gt_o = num1_i > num2_i;
  assign lt_o = num1_i < num2_i;
endmodule

// state   | meaning
// IDLE    | no run; waits for start, results held
// WAIT    | ready for next sample
// CMP_MAX | compare latched sample against running max
// CMP_MIN | compare latched sample against running min, advance index
// DONE    | one-cycle completion pulse
module cmp_minmax_seq #(
  parameter int unsigned COUNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       in_valid_i,
  input  logic [3:0] in_data_i,
  output logic       in_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] max_out_o,
  output logic [3:0] min_out_o,
  output logic [3:0] max_idx_o,
  output logic [3:0] min_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] LAST   = 4'(COUNT - 1);
  localparam bit         SINGLE = (COUNT == 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] smp_q, smp_d;
  logic [3:0] max_q, max_d;
  logic [3:0] min_q, min_d;
  logic [3:0] max_idx_q, max_idx_d;
  logic [3:0] min_idx_q, min_idx_d;
  logic       in_ready_q, busy_q, done_q;

  logic [3:0] cmp_num2;
  logic       cmp_gt, cmp_lt;

  // The single comparator sees the running max only in CMP_MAX.
  assign cmp_num2 = (state_q == S_CMP_MAX) ? max_q : min_q;

  cmp u_cmp (
    .num1_i (smp_q),
    .num2_i (cmp_num2),
    .gt_o   (cmp_gt),
    .lt_o   (cmp_lt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    smp_d     = smp_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_WAIT;
          cnt_d     = 4'd0;
          max_d     = 4'd0;
          min_d     = 4'd0;
          max_idx_d = 4'd0;
          min_idx_d = 4'd0;
        end
      end
      S_WAIT: begin
        if (in_valid_i) begin
          smp_d = in_data_i;
          if (cnt_q == 4'd0) begin
            max_d     = in_data_i;
            min_d     = in_data_i;
            max_idx_d = 4'd0;
            min_idx_d = 4'd0;
            cnt_d     = cnt_q + 4'd1;
            state_d   = SINGLE ? S_DONE : S_WAIT;
          end else begin
            state_d = S_CMP_MAX;
          end
        end
      end
      S_CMP_MAX: begin
        // Strict compare keeps the earliest index on ties.
        if (cmp_gt) begin
          max_d     = smp_q;
          max_idx_d = cnt_q;
        end
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        if (cmp_lt) begin
          min_d     = smp_q;
          min_idx_d = cnt_q;
        end
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == LAST) ? S_DONE : S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      smp_q      <= 4'd0;
      max_q      <= 4'd0;
      min_q      <= 4'd0;
      max_idx_q  <= 4'd0;
      min_idx_q  <= 4'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      max_q      <= max_d;
      min_q      <= min_d;
      max_idx_q  <= max_idx_d;
      min_idx_q  <= min_idx_d;
      in_ready_q <= (state_d == S_WAIT);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign in_ready_o = in_ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign max_out_o  = max_q;
  assign min_out_o  = min_q;
  assign max_idx_o  = max_idx_q;
  assign min_idx_o  = min_idx_q;

endmodule
